// File: rtl/alarm_tone_sequencer.sv
// Alarm buzzer: steps through NUM_TONES square-wave pitches in an on/off beep cadence
// until stopped. Define ALARM_TIMEOUT_EN to auto-stop after TIMEOUT_N completed beeps.
module alarm_tone_sequencer #(
    parameter int DIV_W     = 22,
    parameter int NUM_TONES = 4,
    parameter int CAD_W     = 26,
    parameter int TIMEOUT_N = 60,
    localparam int IDX_W    = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic [NUM_TONES*DIV_W-1:0] tone_tbl,
    input  logic [CAD_W-1:0]           on_cyc,
    input  logic [CAD_W-1:0]           off_cyc,
    output logic                       sound,
    output logic                       ringing,
    output logic [IDX_W-1:0]           tone_idx,
    output logic                       timeout
);

    typedef enum logic [1:0] {S_IDLE, S_BEEP, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt, div_d;
    logic [CAD_W-1:0] cad_cnt, cad_d, on_end;
    logic [IDX_W-1:0] idx_d, idx_next;
    logic             sound_d, on_last, off_last, div_hit, beep_limit;
    logic [DIV_W-1:0] tone_arr [NUM_TONES];

    for (genvar k = 0; k < NUM_TONES; k++) begin : g_tone
        assign tone_arr[k] = tone_tbl[k*DIV_W +: DIV_W];
    end

    // A zero beep length still produces a one-cycle beep.
    assign on_end   = (on_cyc == '0) ? '0 : on_cyc - CAD_W'(1);
    assign on_last  = (cad_cnt == on_end);
    assign off_last = (cad_cnt == off_cyc - CAD_W'(1));
    assign div_hit  = (div_cnt == tone_arr[tone_idx]);
    assign idx_next = (tone_idx == IDX_W'(NUM_TONES - 1)) ? '0 : tone_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            div_cnt  <= '0;
            cad_cnt  <= '0;
            tone_idx <= '0;
            sound    <= 1'b0;
            ringing  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_cnt  <= div_d;
            cad_cnt  <= cad_d;
            tone_idx <= idx_d;
            sound    <= sound_d;
            ringing  <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_BEEP;
                S_BEEP:  if (on_last) state_d = beep_limit ? S_IDLE :
                                                (off_cyc != '0) ? S_GAP : S_BEEP;
                S_GAP:   if (off_last) state_d = S_BEEP;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        div_d   = div_cnt;
        cad_d   = cad_cnt;
        idx_d   = tone_idx;
        sound_d = sound;
        case (state_q)
            S_BEEP: begin
                if (on_last) begin
                    cad_d   = '0;
                    div_d   = '0;
                    sound_d = 1'b0;
                    if (off_cyc == '0) idx_d = idx_next;
                end else begin
                    cad_d = cad_cnt + CAD_W'(1);
                    if (div_hit) begin
                        div_d   = '0;
                        sound_d = ~sound;
                    end else begin
                        div_d = div_cnt + DIV_W'(1);
                    end
                end
            end
            S_GAP: begin
                sound_d = 1'b0;
                div_d   = '0;
                if (off_last) begin
                    cad_d = '0;
                    idx_d = idx_next;
                end else begin
                    cad_d = cad_cnt + CAD_W'(1);
                end
            end
            default: begin
                div_d   = '0;
                cad_d   = '0;
                idx_d   = '0;
                sound_d = 1'b0;
            end
        endcase
        // Stop or auto-stop: everything returns to its idle value.
        if (state_d == S_IDLE) begin
            div_d   = '0;
            cad_d   = '0;
            idx_d   = '0;
            sound_d = 1'b0;
        end
    end

`ifdef ALARM_TIMEOUT_EN
    localparam int BC_W = $clog2(TIMEOUT_N + 1);

    logic [BC_W-1:0] beep_cnt, beep_d;
    logic            timeout_d;

    assign beep_limit = (beep_cnt == BC_W'(TIMEOUT_N - 1));
    assign timeout_d  = !stop && (state_q == S_BEEP) && on_last && beep_limit;

    always_comb begin
        beep_d = beep_cnt;
        if (state_d == S_IDLE)
            beep_d = '0;
        else if (state_q == S_BEEP && on_last)
            beep_d = beep_cnt + BC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            beep_cnt <= beep_d;
            timeout  <= timeout_d;
        end
    end
`else
    assign beep_limit = 1'b0;
    assign timeout    = 1'b0;
`endif

endmodule
